// File: rtl/mul32_pkg.sv
// rtl/mul32_pkg.sv - shared constants, column geometry helpers and FSM encoding for the multiplier loader
package mul32_pkg;

    localparam int W    = 32;
    localparam int NCOL = 2 * W - 1;
    localparam int KW   = $clog2(W);

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t LOAD = 2'd1;
    localparam state_t WAIT = 2'd2;
    localparam state_t HOLD = 2'd3;

    // Number of partial-product terms that land in column i.
    function automatic int col_height(input int i);
        return (i + 1 < NCOL - i) ? (i + 1) : (NCOL - i);
    endfunction

    // Lowest multiplicand index contributing to column i.
    function automatic int col_jlo(input int i);
        return (i > W - 1) ? (i - (W - 1)) : 0;
    endfunction

endpackage

// File: rtl/mul32_pp_slice.sv
// rtl/mul32_pp_slice.sv - combinational partial-product bit per column for load cycle k
module mul32_pp_slice import mul32_pkg::*; (
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [KW-1:0]   k,
    output logic [NCOL-1:0] col_bit
);

    for (genvar i = 0; i < NCOL; i++) begin : g_col
        localparam int H    = col_height(i);
        localparam int JLO  = col_jlo(i);
        localparam int SKIP = W - H;

        logic [KW-1:0] ia;
        logic [KW-1:0] ib;
        logic          pp;

        // Short columns idle for SKIP cycles so their terms end up at the capture end.
        always_comb begin
            ia = '0;
            ib = '0;
            pp = 1'b0;
            if (int'(k) >= SKIP) begin
                ia = KW'(JLO + int'(k) - SKIP);
                ib = KW'(i - JLO - (int'(k) - SKIP));
                pp = a[ia] & b[ib];
            end
        end

        assign col_bit[i] = pp;
    end

endmodule

// File: rtl/mul32_serial_loader.sv
// rtl/mul32_serial_loader.sv - serial operand loader and result capture for the compressor harness
module mul32_serial_loader #(
    parameter int W            = 32,
    parameter int COMP_LATENCY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-2:0]   col_bit,
    input  logic [2*W-1:0]   dst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   product,
    output logic             mismatch
);

    import mul32_pkg::*;

    localparam int KL = $clog2(W);

    state_t          state;
    logic [KL-1:0]   k;
    logic [7:0]      wcnt;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [2*W-1:0]  exp_q;
    logic [2*W-2:0]  pp_bits;

    mul32_pp_slice u_pp (
        .a       (a_q),
        .b       (b_q),
        .k       (k),
        .col_bit (pp_bits)
    );

    assign in_ready = (state == IDLE);
    // Gated by state so an async reset clears the serial lines immediately.
    assign col_bit  = (state == LOAD) ? pp_bits : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            wcnt      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            exp_q     <= '0;
            product   <= '0;
            mismatch  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        exp_q <= (2*W)'(a) * (2*W)'(b);
                        k     <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    k <= k + 1'b1;
                    if (k == KL'(W - 1)) begin
                        wcnt  <= 8'(COMP_LATENCY);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (wcnt == 8'd0) begin
                        product   <= dst;
                        mismatch  <= (dst != exp_q);
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        wcnt <= wcnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul32_serial_loader.sv
// tb/tb_mul32_serial_loader.sv - scoreboard bench with a behavioural shift-register/compressor model
module tb_mul32_serial_loader;

    localparam int W    = 32;
    localparam int NCOL = 2 * W - 1;

    typedef struct packed {
        logic [2*W-1:0] p;
        logic           m;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     a_in = '0;
    logic [W-1:0]     b_in = '0;
    logic [NCOL-1:0]  col_bit;
    logic [2*W-1:0]   dst;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2*W-1:0]   product;
    logic             mismatch;

    logic [2*W-1:0]   fault_mask = '0;
    logic [2*W-1:0]   dst_model;
    logic [W-1:0]     sr [NCOL];

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    mul32_serial_loader #(.W(W), .COMP_LATENCY(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_in),
        .b         (b_in),
        .col_bit   (col_bit),
        .dst       (dst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .mismatch  (mismatch)
    );

    // Free-running per-column shift registers feeding a zero-latency counting compressor.
    always @(posedge clk) begin
        for (int i = 0; i < NCOL; i++)
            sr[i] <= {sr[i][W-2:0], col_bit[i]};
    end

    always_comb begin
        dst_model = '0;
        for (int i = 0; i < NCOL; i++)
            dst_model = dst_model + ((2*W)'($countones(sr[i])) << i);
    end

    assign dst = dst_model ^ fault_mask;

    // colmode: 0 no column check, 1 all zero, 2 only column 31 at k=0.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] mask, input int colmode, input int hold);
        int             lat;
        exp_t           e;
        logic [NCOL-1:0] exp_col;
        logic [NCOL-1:0] one31;
        lat = -1;
        one31 = '0;
        one31[31] = 1'b1;
        @(negedge clk);
        fault_mask = mask;
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: in_ready=%0b want 1", in_ready);
        end
        @(posedge clk);
        sb.push_back('{p: ((2*W)'(a) * (2*W)'(b)) ^ mask, m: (mask != '0)});
        @(negedge clk);
        in_valid = 1'b0;
        a_in = ~a;
        b_in = ~b;
        for (int m = 0; m < 60; m++) begin
            if (m < W && colmode != 0) begin
                exp_col = (colmode == 2 && m == 0) ? one31 : '0;
                vectors++;
                if (col_bit !== exp_col) begin
                    errors++;
                    $display("FAIL col_bit k=%0d: got %h want %h", m, col_bit, exp_col);
                end
            end
            if (m == 5) begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_ready: in_ready=%0b want 0", in_ready);
                end
            end
            if (out_valid === 1'b1) begin
                lat = m;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        vectors++;
        if (lat != W + 1) begin
            errors++;
            $display("FAIL latency: got %0d want %0d", lat, W + 1);
        end
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: empty on output");
            return;
        end
        e = sb.pop_front();
        vectors++;
        if (product !== e.p) begin
            errors++;
            $display("FAIL product: got %h want %h", product, e.p);
        end
        vectors++;
        if (mismatch !== e.m) begin
            errors++;
            $display("FAIL mismatch: got %0b want %0b", mismatch, e.m);
        end
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a_in = 32'hDEAD0000 + 32'(h);
            b_in = 32'h0000BEEF;
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (product !== e.p || mismatch !== e.m || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold cyc=%0d: product=%h mismatch=%0b in_ready=%0b out_valid=%0b want %h %0b 0 1",
                         h, product, mismatch, in_ready, out_valid, e.p, e.m);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release: in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid);
        end
        fault_mask = '0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0 || mismatch !== 1'b0 || col_bit !== '0) begin
            errors++;
            $display("FAIL reset: in_ready=%0b out_valid=%0b product=%h mismatch=%0b col_bit=%h want 1 0 0 0 0",
                     in_ready, out_valid, product, mismatch, col_bit);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_op(32'd3, 32'd5, '0, 0, 0);
    endtask

    task automatic test_full_scale();
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, '0, 0, 0);
    endtask

    task automatic test_zero();
        do_op(32'd0, 32'h12345678, '0, 1, 0);
    endtask

    task automatic test_column_order();
        do_op(32'd1, 32'h80000000, '0, 2, 0);
    endtask

    task automatic test_backpressure();
        do_op(32'h0001_2345, 32'h0000_0ABC, '0, 0, 10);
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk);
        a_in = 32'hFFFFFFFF;
        b_in = 32'hFFFFFFFF;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        vectors++;
        if (col_bit === '0) begin
            errors++;
            $display("FAIL load_k10_active: col_bit=%h want nonzero", col_bit);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (col_bit !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_load: col_bit=%h in_ready=%0b out_valid=%0b want 0 1 0",
                     col_bit, in_ready, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'd7, 32'd9, '0, 0, 0);
    endtask

    task automatic test_fault();
        logic [2*W-1:0] mask;
        mask = '0;
        mask[5] = 1'b1;
        do_op(32'd2, 32'd3, mask, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++)
            do_op($urandom, $urandom, '0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_scale();
        test_zero();
        test_column_order();
        test_backpressure();
        test_reset_mid_load();
        test_fault();
        test_back_to_back();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
